// File: rtl/matrix_mac_engine.sv
// Sequential matrix multiplier C = A x B built around one reused multiply-accumulate unit.
// Results are staged in a shadow buffer and published to C_out in one step on completion.
module matrix_mac_engine #(
    parameter int unsigned ROWS_A       = 2,
    parameter int unsigned COLS_A       = 3,
    parameter int unsigned COLS_B       = 2,
    parameter int unsigned ELEM_WIDTH   = 8,
    parameter int unsigned RESULT_WIDTH = 16,
    parameter bit          SIGNED       = 1'b0,
    parameter bit          SATURATE     = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [ROWS_A*COLS_A*ELEM_WIDTH-1:0]    A_in,
    input  logic [COLS_A*COLS_B*ELEM_WIDTH-1:0]    B_in,
    output logic [ROWS_A*COLS_B*RESULT_WIDTH-1:0]  C_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow
);
    localparam int unsigned ACC_W = 2 * ELEM_WIDTH + $clog2(COLS_A) + 1;
    localparam int unsigned XW    = (ACC_W > RESULT_WIDTH) ? ACC_W : RESULT_WIDTH + 1;
    localparam int unsigned IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int unsigned KW    = (COLS_A > 1) ? $clog2(COLS_A) : 1;
    localparam int unsigned JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;

    typedef enum logic [1:0] {StIdle, StMac, StWrite} state_e;

    state_e                  state_q;
    logic [IW-1:0]           i_q;
    logic [KW-1:0]           k_q;
    logic [JW-1:0]           j_q;
    logic [ACC_W-1:0]        acc_q;
    logic                    sh_ovf_q;
    logic                    busy_q, done_q, ovf_q;
    logic [ELEM_WIDTH-1:0]   a_q  [ROWS_A][COLS_A];
    logic [ELEM_WIDTH-1:0]   b_q  [COLS_A][COLS_B];
    logic [RESULT_WIDTH-1:0] sh_q [ROWS_A][COLS_B];
    logic [RESULT_WIDTH-1:0] c_q  [ROWS_A][COLS_B];

    logic [ELEM_WIDTH-1:0]   a_in_arr [ROWS_A][COLS_A];
    logic [ELEM_WIDTH-1:0]   b_in_arr [COLS_A][COLS_B];

    for (genvar r = 0; r < ROWS_A; r++) begin : g_a_rows
        for (genvar c = 0; c < COLS_A; c++) begin : g_a_cols
            assign a_in_arr[r][c] = A_in[(r*COLS_A+c)*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end
    for (genvar r = 0; r < COLS_A; r++) begin : g_b_rows
        for (genvar c = 0; c < COLS_B; c++) begin : g_b_cols
            assign b_in_arr[r][c] = B_in[(r*COLS_B+c)*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end
    for (genvar r = 0; r < ROWS_A; r++) begin : g_c_rows
        for (genvar c = 0; c < COLS_B; c++) begin : g_c_cols
            assign C_out[(r*COLS_B+c)*RESULT_WIDTH +: RESULT_WIDTH] = c_q[r][c];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

    logic [ACC_W-1:0]        a_ext, b_ext, prod;
    logic [XW-1:0]           acc_x;
    logic                    el_ovf;
    logic [RESULT_WIDTH-1:0] res, sat_hi, sat_lo;

    always_comb begin
        if (SIGNED) begin
            a_ext = ACC_W'($signed(a_q[i_q][k_q]));
            b_ext = ACC_W'($signed(b_q[k_q][j_q]));
            acc_x = XW'($signed(acc_q));
        end else begin
            a_ext = ACC_W'(a_q[i_q][k_q]);
            b_ext = ACC_W'(b_q[k_q][j_q]);
            acc_x = XW'(acc_q);
        end
        // Low ACC_W bits of the product are exact for both encodings
        prod   = a_ext * b_ext;
        sat_hi = '1;
        sat_lo = '0;
        if (SIGNED) begin
            sat_hi[RESULT_WIDTH-1] = 1'b0;
            sat_lo[RESULT_WIDTH-1] = 1'b1;
            el_ovf = !((&acc_x[XW-1:RESULT_WIDTH-1]) || !(|acc_x[XW-1:RESULT_WIDTH-1]));
        end else begin
            el_ovf = |acc_x[XW-1:RESULT_WIDTH];
        end
        if (el_ovf && SATURATE) begin
            res = (SIGNED && acc_x[XW-1]) ? sat_lo : sat_hi;
        end else begin
            res = acc_x[RESULT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            i_q      <= '0;
            k_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            sh_ovf_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int r = 0; r < ROWS_A; r++) begin
                for (int c = 0; c < COLS_A; c++) a_q[r][c] <= '0;
                for (int c = 0; c < COLS_B; c++) begin
                    sh_q[r][c] <= '0;
                    c_q[r][c]  <= '0;
                end
            end
            for (int r = 0; r < COLS_A; r++) begin
                for (int c = 0; c < COLS_B; c++) b_q[r][c] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        a_q      <= a_in_arr;
                        b_q      <= b_in_arr;
                        i_q      <= '0;
                        k_q      <= '0;
                        j_q      <= '0;
                        acc_q    <= '0;
                        sh_ovf_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StMac;
                    end
                end
                StMac: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_q + prod;
                        if (k_q == KW'(COLS_A - 1)) state_q <= StWrite;
                        else                        k_q     <= k_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        sh_q[i_q][j_q] <= res;
                        sh_ovf_q       <= sh_ovf_q | el_ovf;
                        acc_q          <= '0;
                        k_q            <= '0;
                        if (i_q == IW'(ROWS_A - 1) && j_q == JW'(COLS_B - 1)) begin
                            c_q            <= sh_q;
                            c_q[i_q][j_q]  <= res;
                            ovf_q          <= sh_ovf_q | el_ovf;
                            done_q         <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            if (j_q == JW'(COLS_B - 1)) begin
                                j_q <= '0;
                                i_q <= i_q + 1'b1;
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                            state_q <= StMac;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: five instances cover default, signed, narrow
// saturating/truncating and 1x1x1 configurations.
module tb_matrix_mac_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] st = '0;
    logic ab = 1'b0;
    logic [47:0] a0, b0, a1, b1, a23, b23;
    logic [7:0]  a4, b4;
    logic [63:0] c0, c1;
    logic [31:0] c2, c3;
    logic [15:0] c4;
    logic [4:0]  bz, dn, ov;
    int total = 0;
    int bad = 0;

    // Row-major, element 0 in the LSBs
    localparam logic [47:0] A_BASIC = {8'd8, 8'd5, 8'd2, 8'd1, 8'd1, 8'd1};
    localparam logic [47:0] B_BASIC = {8'd8, 8'd1, 8'd5, 8'd1, 8'd2, 8'd1};
    localparam logic [63:0] C_BASIC = {16'd93, 16'd15, 16'd15, 16'd3};
    localparam logic [47:0] A_OP2   = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [47:0] B_OP2   = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [63:0] C_OP2   = {16'd64, 16'd49, 16'd28, 16'd22};
    localparam logic [47:0] A_SGN   = {8'h06, 8'hFB, 8'h04, 8'hFD, 8'h02, 8'hFF};
    localparam logic [47:0] B_SGN   = {8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    localparam logic [63:0] C_SGN   = {16'h0001, 16'h000A, 16'hFFFF, 16'hFFFC};
    localparam logic [47:0] A_SSAT  = {6{8'h80}};
    localparam logic [47:0] B_SSAT  = {8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
    localparam logic [63:0] C_SSAT  = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};

    always #5 clk = ~clk;

    matrix_mac_engine u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab), .A_in(a0), .B_in(b0),
        .C_out(c0), .busy(bz[0]), .done(dn[0]), .overflow(ov[0])
    );
    matrix_mac_engine #(.SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(1'b0), .A_in(a1), .B_in(b1),
        .C_out(c1), .busy(bz[1]), .done(dn[1]), .overflow(ov[1])
    );
    matrix_mac_engine #(.RESULT_WIDTH(8), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .abort(1'b0), .A_in(a23), .B_in(b23),
        .C_out(c2), .busy(bz[2]), .done(dn[2]), .overflow(ov[2])
    );
    matrix_mac_engine #(.RESULT_WIDTH(8), .SATURATE(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .start(st[3]), .abort(1'b0), .A_in(a23), .B_in(b23),
        .C_out(c3), .busy(bz[3]), .done(dn[3]), .overflow(ov[3])
    );
    matrix_mac_engine #(.ROWS_A(1), .COLS_A(1), .COLS_B(1)) u_dut4 (
        .clk(clk), .rst(rst), .start(st[4]), .abort(1'b0), .A_in(a4), .B_in(b4),
        .C_out(c4), .busy(bz[4]), .done(dn[4]), .overflow(ov[4])
    );

    // Called #1 after an edge; returns edges from the start edge to done (-1 on timeout)
    task automatic run_op(input int d, output int lat, output int bcnt);
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        lat  = 0;
        bcnt = bz[d] ? 1 : 0;
        while (!dn[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bz[d]) bcnt++;
        end
        if (!dn[d]) lat = -1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total++; if (c0 !== 64'd0) begin bad++; $display("FAIL reset_c: got %h want 0", c0); end
        total++; if (bz[0] !== 1'b0 || dn[0] !== 1'b0 || ov[0] !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got busy=%b done=%b ovf=%b want 000", bz[0], dn[0], ov[0]);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        total++; if (bz !== 5'd0) begin bad++; $display("FAIL reset_busy_all: got %b want 0", bz); end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        a0 = A_BASIC; b0 = B_BASIC;
        run_op(0, lat, bcnt);
        total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency: got %0d want 16", lat); end
        total++; if (bcnt !== 16) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 16", bcnt); end
        total++; if (c0 !== C_BASIC) begin bad++; $display("FAIL basic_c: got %h want %h", c0, C_BASIC); end
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ov[0]); end
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", bz[0]); end
        @(posedge clk); #1;
        total++; if (dn[0] !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", dn[0]); end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        a1 = A_SGN; b1 = B_SGN;
        run_op(1, lat, bcnt);
        total++; if (c1 !== C_SGN) begin bad++; $display("FAIL signed_c: got %h want %h", c1, C_SGN); end
        total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL signed_ovf: got %b want 0", ov[1]); end
        a1 = A_SSAT; b1 = B_SSAT;
        run_op(1, lat, bcnt);
        total++; if (c1 !== C_SSAT) begin bad++; $display("FAIL signed_sat_c: got %h want %h", c1, C_SSAT); end
        total++; if (ov[1] !== 1'b1) begin bad++; $display("FAIL signed_sat_ovf: got %b want 1", ov[1]); end
        a1 = A_SGN; b1 = B_SGN;
        run_op(1, lat, bcnt);
        total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL signed_ovf_clear: got %b want 0", ov[1]); end
    endtask

    task automatic test_narrow();
        int lat, bcnt;
        a23 = '1; b23 = '1;
        run_op(2, lat, bcnt);
        total++; if (c2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_c: got %h want ffffffff", c2); end
        total++; if (ov[2] !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b want 1", ov[2]); end
        // 3*255*255 = 195075 = 0x2FA03
        run_op(3, lat, bcnt);
        total++; if (c3 !== 32'h0303_0303) begin bad++; $display("FAIL trunc_c: got %h want 03030303", c3); end
        total++; if (ov[3] !== 1'b1) begin bad++; $display("FAIL trunc_ovf: got %b want 1", ov[3]); end
    endtask

    task automatic test_min_config();
        int lat, bcnt;
        a4 = 8'd7; b4 = 8'd9;
        run_op(4, lat, bcnt);
        total++; if (lat !== 2) begin bad++; $display("FAIL min_latency: got %0d want 2", lat); end
        total++; if (c4 !== 16'd63) begin bad++; $display("FAIL min_c: got %h want 003f", c4); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        a0 = A_OP2; b0 = B_OP2;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        a0 = '0; b0 = '0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            st[0] = (cyc == 3);
            if (st[0]) begin a0 = A_BASIC; b0 = B_BASIC; end
            if (cyc == 3) begin
                total++; if (c0 !== C_BASIC) begin bad++; $display("FAIL ign_hold_c: got %h want %h", c0, C_BASIC); end
            end
            if (dn[0]) break;
        end
        st[0] = 1'b0;
        total++; if (cyc !== 16) begin bad++; $display("FAIL ign_latency: got %0d want 16", cyc); end
        total++; if (c0 !== C_OP2) begin bad++; $display("FAIL ign_c: got %h want %h", c0, C_OP2); end
        @(posedge clk); #1;
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL ign_no_restart: got %b want 0", bz[0]); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        a0 = A_BASIC; b0 = B_BASIC;
        run_op(0, lat, bcnt);
        total++; if (c0 !== C_BASIC) begin bad++; $display("FAIL b2b_first_c: got %h want %h", c0, C_BASIC); end
        a0 = A_OP2; b0 = B_OP2;
        run_op(0, lat, bcnt);
        total++; if (lat !== 16) begin bad++; $display("FAIL b2b_latency: got %0d want 16", lat); end
        total++; if (c0 !== C_OP2) begin bad++; $display("FAIL b2b_second_c: got %h want %h", c0, C_OP2); end
    endtask

    task automatic test_abort();
        int lat, bcnt, dcnt;
        a0 = A_BASIC; b0 = B_BASIC;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 ab = 1'b1;
        @(posedge clk); #1;
        ab = 1'b0;
        total++; if (bz[0] !== 1'b0 || dn[0] !== 1'b0) begin
            bad++; $display("FAIL abort_flags: got busy=%b done=%b want 00", bz[0], dn[0]);
        end
        dcnt = 0;
        repeat (20) begin @(posedge clk); #1; if (dn[0]) dcnt++; end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dcnt); end
        total++; if (c0 !== C_OP2) begin bad++; $display("FAIL abort_hold_c: got %h want %h", c0, C_OP2); end
        run_op(0, lat, bcnt);
        total++; if (lat !== 16 || c0 !== C_BASIC) begin
            bad++; $display("FAIL abort_restart: got lat=%0d c=%h want lat=16 c=%h", lat, c0, C_BASIC);
        end
        ab = 1'b1; st[0] = 1'b1;
        @(posedge clk); #1;
        ab = 1'b0; st[0] = 1'b0;
        total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL abort_start_idle: got %b want 0", bz[0]); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        a0 = A_OP2; b0 = B_OP2;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (c0 !== 64'd0 || bz[0] !== 1'b0 || dn[0] !== 1'b0) begin
            bad++; $display("FAIL rmid_outputs: got c=%h busy=%b done=%b want 0", c0, bz[0], dn[0]);
        end
        total++; if (ov[2] !== 1'b0 || c2 !== 32'd0) begin
            bad++; $display("FAIL rmid_ovf: got ovf=%b c=%h want 0", ov[2], c2);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_op(0, lat, bcnt);
        total++; if (lat !== 16 || c0 !== C_OP2) begin
            bad++; $display("FAIL rmid_restart: got lat=%0d c=%h want lat=16 c=%h", lat, c0, C_OP2);
        end
    endtask

    initial begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a23 = '0; b23 = '0; a4 = '0; b4 = '0;
        test_reset();
        test_basic();
        test_signed();
        test_narrow();
        test_min_config();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
